// File: rtl/barret_2131_arbiter.sv
// rtl/barret_2131_arbiter.sv - round-robin arbiter sharing one mod-2131 Barrett reducer
// Requests pass through stage A (operand) and stage B (result) registers around the reducer.

module barret_for_2131 (
  input  logic [22:0] din_a,
  output logic [11:0] dout_r
);
  localparam int unsigned K = 35;
  localparam logic [46:0] M = 47'((64'd1 << K) / 64'd2131);

  logic [11:0] q_est;
  logic [12:0] r_est;

  // floor(x*M / 2^K) undershoots x/2131 by at most one, so one correction step suffices
  always_comb begin
    q_est  = 12'((47'(din_a) * M) >> K);
    r_est  = 13'(24'(din_a) - 24'(q_est) * 24'd2131);
    dout_r = (r_est >= 13'd2131) ? 12'(r_est - 13'd2131) : r_est[11:0];
  end
endmodule

module barret_2131_arbiter #(
  parameter int          N_REQ  = 4,
  parameter int          ID_W   = 2,
  parameter int          IN_W   = 23,
  parameter int          OUT_W  = 12,
  parameter int unsigned MAX_OP = 4536900
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*IN_W-1:0]   req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  output logic [OUT_W-1:0]        rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_oor,
  input  logic                    rsp_ready,
  output logic                    busy
);
  logic              a_valid_q, a_valid_d;
  logic [IN_W-1:0]   a_data_q, a_data_d;
  logic [ID_W-1:0]   a_id_q, a_id_d;
  logic              a_oor_q, a_oor_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [OUT_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_oor_q, rsp_oor_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic [ID_W-1:0]   grant;
  logic              found;
  int                idx;
  logic              b_load;
  logic              a_accept_ok;
  logic              xfer;
  logic [IN_W-1:0]   sel_data;
  logic [11:0]       red_out;

  barret_for_2131 u_reducer (
    .din_a  (a_data_q),
    .dout_r (red_out)
  );

  assign b_load      = a_valid_q && (!rsp_valid_q || rsp_ready);
  assign a_accept_ok = !a_valid_q || b_load;

  // Search starts at the pointer so the last winner drops to lowest priority
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  assign sel_data = req_data[grant*IN_W +: IN_W];
  assign xfer     = !rst && found && a_accept_ok;

  always_comb begin
    req_ready = '0;
    if (!rst && found) req_ready[grant] = a_accept_ok;
  end

  always_comb begin
    a_valid_d   = a_valid_q;
    a_data_d    = a_data_q;
    a_id_d      = a_id_q;
    a_oor_d     = a_oor_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_oor_d   = rsp_oor_q;

    if (xfer) begin
      a_valid_d = 1'b1;
      a_data_d  = sel_data;
      a_id_d    = grant;
      a_oor_d   = (sel_data > IN_W'(MAX_OP));
      ptr_d     = (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
    end else if (b_load) begin
      a_valid_d = 1'b0;
    end

    if (b_load) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = OUT_W'(red_out);
      rsp_id_d    = a_id_q;
      rsp_oor_d   = a_oor_q;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q   <= 1'b0;
      a_data_q    <= '0;
      a_id_q      <= '0;
      a_oor_q     <= 1'b0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_oor_q   <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_data_q    <= a_data_d;
      a_id_q      <= a_id_d;
      a_oor_q     <= a_oor_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_oor_q   <= rsp_oor_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_oor   = rsp_oor_q;
  assign busy      = a_valid_q || rsp_valid_q;
endmodule

// File: tb/tb_barret_2131_arbiter.sv
// tb/tb_barret_2131_arbiter.sv - directed vectors and scoreboard for barret_2131_arbiter
module tb_barret_2131_arbiter;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int IN_W  = 23;
  localparam int OUT_W = 12;
  localparam int unsigned MAX_OP = 4536900;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*IN_W-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsp_valid;
  logic [OUT_W-1:0]      rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_oor;
  logic                  rsp_ready;
  logic                  busy;

  barret_2131_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .IN_W(IN_W), .OUT_W(OUT_W), .MAX_OP(MAX_OP)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_oor(rsp_oor), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] id; logic [11:0] r; logic oor; } exp_t;
  typedef struct { logic [1:0] id; logic [22:0] op; logic [11:0] exp_data; logic exp_oor; } vec_t;

  vec_t        vecs [8];
  logic [22:0] src [4][$];
  exp_t        exp_q [$];
  int          checks = 0;
  int          passed = 0;
  int          rsp_count = 0;
  logic        hold_pending = 1'b0;
  logic [11:0] hold_data;
  logic [1:0]  hold_id;
  logic        hold_oor;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) src[i].delete();
    exp_q.delete();
    hold_pending = 1'b0;
  endtask

  // One clock: drive, sample handshakes at +1, then advance to posedge+1
  task automatic cycle(input logic [3:0] want, input logic rr, input logic [3:0] exp_rdy, input bit chk_rdy);
    logic [3:0]  v;
    exp_t        e;
    logic [22:0] op;
    for (int i = 0; i < 4; i++) begin
      v[i] = want[i] && (src[i].size() > 0);
      req_data[i*IN_W +: IN_W] = (src[i].size() > 0) ? src[i][0] : 23'd0;
    end
    req_valid = v;
    rsp_ready = rr;
    #1;
    if (chk_rdy) chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (hold_pending) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'(hold_data));
      chk("hold_id", 32'(rsp_id), 32'(hold_id));
      chk("hold_oor", 32'(rsp_oor), 32'(hold_oor));
    end
    hold_pending = rsp_valid && !rsp_ready;
    hold_data = rsp_data;
    hold_id   = rsp_id;
    hold_oor  = rsp_oor;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_rsp: got id %0d data %0d, expected no response", rsp_id, rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_oor", 32'(rsp_oor), 32'(e.oor));
        if (!e.oor) chk("rsp_data", 32'(rsp_data), 32'(e.r));
        rsp_count++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        op = src[i].pop_front();
        exp_q.push_back('{id: 2'(i), r: 12'(op % 23'd2131), oor: (op > 23'(MAX_OP))});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || busy) && n < 50) begin
      cycle(4'b0000, 1'b1, 4'b0000, 1'b0);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic stream(input int max_cyc, input bit rnd);
    int n = 0;
    while ((src[0].size() + src[1].size() + src[2].size() + src[3].size()) > 0 && n < max_cyc) begin
      if (rnd) cycle(4'($urandom), 1'($urandom_range(0, 1)), 4'b0000, 1'b0);
      else     cycle(4'b1000, 1'b1, 4'b0000, 1'b0);
      n++;
    end
    chk("stream_left", 32'(src[0].size() + src[1].size() + src[2].size() + src[3].size()), 32'd0);
    drain();
  endtask

  task automatic single(input int k, input logic [1:0] id, input logic [22:0] op,
                        input logic [11:0] exp_d, input logic exp_oor);
    req_valid = 4'b0001 << id;
    req_data  = '0;
    req_data[id*IN_W +: IN_W] = op;
    rsp_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_ready", k), 32'(req_ready), 32'(4'b0001 << id));
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    chk($sformatf("v%0d_lat1", k), 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_valid", k), 32'(rsp_valid), 32'd1);
    chk($sformatf("v%0d_id", k), 32'(rsp_id), 32'(id));
    chk($sformatf("v%0d_oor", k), 32'(rsp_oor), 32'(exp_oor));
    if (!exp_oor) chk($sformatf("v%0d_data", k), 32'(rsp_data), 32'(exp_d));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_clear", k), 32'(rsp_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  logic [3:0] cont_rdy [6];
  logic [3:0] bp_rdy [9];
  logic       bp_rr  [9];
  int         rc0;

  initial begin
    vecs[0] = '{2'd0, 23'd4536900, 12'd1,    1'b0};
    vecs[1] = '{2'd0, 23'd0,       12'd0,    1'b0};
    vecs[2] = '{2'd1, 23'd2130,    12'd2130, 1'b0};
    vecs[3] = '{2'd2, 23'd2131,    12'd0,    1'b0};
    vecs[4] = '{2'd3, 23'd2132,    12'd1,    1'b0};
    vecs[5] = '{2'd0, 23'd4262,    12'd0,    1'b0};
    vecs[6] = '{2'd1, 23'd4536901, 12'd0,    1'b1};
    vecs[7] = '{2'd2, 23'd8388607, 12'd0,    1'b1};
    cont_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    bp_rdy   = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    bp_rr    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_oor", 32'(rsp_oor), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    req_valid = 4'b0000;

    for (int k = 0; k < 8; k++)
      single(k, vecs[k].id, vecs[k].op, vecs[k].exp_data, vecs[k].exp_oor);

    // Full contention from a fresh pointer, includes the 3 -> 0 wrap
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      src[i].push_back(23'(213100 + i));
      src[i].push_back(23'(213100 + i));
    end
    rc0 = rsp_count;
    for (int c = 0; c < 6; c++) cycle(4'b1111, 1'b1, cont_rdy[c], 1'b1);
    cycle(4'b0000, 1'b1, 4'b0000, 1'b0);
    cycle(4'b0000, 1'b1, 4'b0000, 1'b0);
    chk("contention_throughput", 32'(rsp_count - rc0), 32'd6);
    drain();
    clear_model();

    // Backpressure on a stream from requester 2
    src[2] = '{23'd7, 23'd2200, 23'd4267, 23'd100000, 23'd106559};
    rc0 = rsp_count;
    for (int c = 0; c < 9; c++) cycle((c < 8) ? 4'b0100 : 4'b0000, bp_rr[c], bp_rdy[c], 1'b1);
    drain();
    chk("bp_count", 32'(rsp_count - rc0), 32'd5);

    // Reset with both stages occupied
    for (int i = 0; i < 4; i++) src[i].push_back(23'(1000 + i));
    cycle(4'b1111, 1'b0, 4'b0000, 1'b0);
    cycle(4'b1111, 1'b0, 4'b0000, 1'b0);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    clear_model();
    req_valid = 4'b1001;
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'd1);
    req_valid = 4'b0000;
    @(posedge clk);
    #1;

    for (int v = 0; v <= 2130; v++) src[3].push_back(23'(v));
    stream(3000, 1'b0);
    for (int n = 0; n < 200; n++)
      src[$urandom_range(0, 3)].push_back(23'($urandom_range(0, MAX_OP)));
    stream(5000, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
